// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with multi-lane write-back, flush, and a valid bit.
// It also saves multi-cycle EX state across stalls and counts inserted bubbles.
module ex_mem_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LANES   = 1,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned STAGE   = 3,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     ex_valid,
    input  logic [LANES*ADDR_W-1:0]  ex_wd,
    input  logic [LANES-1:0]         ex_wreg,
    input  logic [LANES*DATA_W-1:0]  ex_wdata,
    input  logic [DATA_W-1:0]        ex_hi,
    input  logic [DATA_W-1:0]        ex_lo,
    input  logic                     ex_we,
    input  logic [DATA_W-1:0]        ex_flags,
    input  logic                     ex_flags_we,
    input  logic [2*DATA_W-1:0]      ex_hilo_tmp,
    input  logic [CNT_W-1:0]         ex_cnt,
    output logic                     mem_valid,
    output logic [LANES*ADDR_W-1:0]  mem_wd,
    output logic [LANES-1:0]         mem_wreg,
    output logic [LANES*DATA_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0]        mem_hi,
    output logic [DATA_W-1:0]        mem_lo,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_flags,
    output logic                     mem_flags_we,
    output logic [2*DATA_W-1:0]      hilo_tmp_o,
    output logic [CNT_W-1:0]         cnt_o,
    output logic [PERF_W-1:0]        bubble_cnt
);

    if (STAGE + 1 >= STALL_W) begin : gen_bad_stage
        $error("ex_mem_pipe: STAGE+1 must be below STALL_W");
    end
    if (LANES < 1 || LANES > 4) begin : gen_bad_lanes
        $error("ex_mem_pipe: LANES must be in 1..4");
    end

    typedef enum logic [1:0] {ActLoad, ActBubble, ActHold, ActFlush} act_e;

    logic  s_here;
    logic  s_next;
    act_e  act;

    // Only our own bit and the next stage's bit matter here.
    logic  unused_stall;
    assign unused_stall = ^stall;

    assign s_here = stall[STAGE];
    assign s_next = stall[STAGE+1];

    // Flush beats any stall; s_here=0 with s_next=1 falls through to LOAD.
    always_comb begin
        act = ActLoad;
        if (flush) begin
            act = ActFlush;
        end else if (s_here && s_next) begin
            act = ActHold;
        end else if (s_here) begin
            act = ActBubble;
        end
    end

    logic                    valid_q,    valid_d;
    logic [LANES*ADDR_W-1:0] wd_q,       wd_d;
    logic [LANES-1:0]        wreg_q,     wreg_d;
    logic [LANES*DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0]       hi_q,       hi_d;
    logic [DATA_W-1:0]       lo_q,       lo_d;
    logic                    we_q,       we_d;
    logic [DATA_W-1:0]       flags_q,    flags_d;
    logic                    flags_we_q, flags_we_d;
    logic [2*DATA_W-1:0]     tmp_q,      tmp_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [PERF_W-1:0]       bubble_q,   bubble_d;
    logic [PERF_W-1:0]       bubble_inc;

    assign bubble_inc = (bubble_q == '1) ? bubble_q : bubble_q + PERF_W'(1);

    always_comb begin
        valid_d    = valid_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        we_d       = we_q;
        flags_d    = flags_q;
        flags_we_d = flags_we_q;
        tmp_d      = tmp_q;
        cnt_d      = cnt_q;
        bubble_d   = bubble_q;
        unique case (act)
            ActFlush, ActBubble: begin
                valid_d    = 1'b0;
                wd_d       = '0;
                wreg_d     = '0;
                wdata_d    = '0;
                hi_d       = '0;
                lo_d       = '0;
                we_d       = 1'b0;
                flags_d    = '0;
                flags_we_d = 1'b0;
                if (act == ActBubble) begin
                    // Park the partial result so EX can resume next cycle.
                    tmp_d    = ex_hilo_tmp;
                    cnt_d    = ex_cnt;
                    bubble_d = bubble_inc;
                end else begin
                    tmp_d = '0;
                    cnt_d = '0;
                end
            end
            ActHold: begin
            end
            ActLoad: begin
                valid_d    = ex_valid;
                wd_d       = ex_wd;
                wreg_d     = ex_wreg;
                wdata_d    = ex_wdata;
                hi_d       = ex_hi;
                lo_d       = ex_lo;
                we_d       = ex_we;
                flags_d    = ex_flags;
                flags_we_d = ex_flags_we;
                tmp_d      = '0;
                cnt_d      = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wd_q       <= '0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            we_q       <= 1'b0;
            flags_q    <= '0;
            flags_we_q <= 1'b0;
            tmp_q      <= '0;
            cnt_q      <= '0;
            bubble_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            we_q       <= we_d;
            flags_q    <= flags_d;
            flags_we_q <= flags_we_d;
            tmp_q      <= tmp_d;
            cnt_q      <= cnt_d;
            bubble_q   <= bubble_d;
        end
    end

    assign mem_valid    = valid_q;
    assign mem_wd       = wd_q;
    assign mem_wreg     = wreg_q;
    assign mem_wdata    = wdata_q;
    assign mem_hi       = hi_q;
    assign mem_lo       = lo_q;
    assign mem_we       = we_q;
    assign mem_flags    = flags_q;
    assign mem_flags_we = flags_we_q;
    assign hilo_tmp_o   = tmp_q;
    assign cnt_o        = cnt_q;
    assign bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe (two lanes, 4-bit bubble counter) against
// a per-cycle behavioural model plus literal spot checks.
module tb_ex_mem_pipe;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned LANES   = 2;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned STAGE   = 3;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned PERF_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic                    ex_valid;
    logic [LANES*ADDR_W-1:0] ex_wd;
    logic [LANES-1:0]        ex_wreg;
    logic [LANES*DATA_W-1:0] ex_wdata;
    logic [DATA_W-1:0]       ex_hi, ex_lo, ex_flags;
    logic                    ex_we, ex_flags_we;
    logic [2*DATA_W-1:0]     ex_hilo_tmp;
    logic [CNT_W-1:0]        ex_cnt;
    logic                    mem_valid;
    logic [LANES*ADDR_W-1:0] mem_wd;
    logic [LANES-1:0]        mem_wreg;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0]       mem_hi, mem_lo, mem_flags;
    logic                    mem_we, mem_flags_we;
    logic [2*DATA_W-1:0]     hilo_tmp_o;
    logic [CNT_W-1:0]        cnt_o;
    logic [PERF_W-1:0]       bubble_cnt;

    ex_mem_pipe #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .LANES (LANES), .STALL_W (STALL_W),
        .STAGE (STAGE), .CNT_W (CNT_W), .PERF_W (PERF_W)
    ) dut (
        .clk (clk), .rst (rst), .stall (stall), .flush (flush), .ex_valid (ex_valid),
        .ex_wd (ex_wd), .ex_wreg (ex_wreg), .ex_wdata (ex_wdata), .ex_hi (ex_hi),
        .ex_lo (ex_lo), .ex_we (ex_we), .ex_flags (ex_flags), .ex_flags_we (ex_flags_we),
        .ex_hilo_tmp (ex_hilo_tmp), .ex_cnt (ex_cnt), .mem_valid (mem_valid),
        .mem_wd (mem_wd), .mem_wreg (mem_wreg), .mem_wdata (mem_wdata), .mem_hi (mem_hi),
        .mem_lo (mem_lo), .mem_we (mem_we), .mem_flags (mem_flags),
        .mem_flags_we (mem_flags_we), .hilo_tmp_o (hilo_tmp_o), .cnt_o (cnt_o),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: expected contents after each edge, derived from the action table.
    logic                    m_valid;
    logic [LANES*ADDR_W-1:0] m_wd;
    logic [LANES-1:0]        m_wreg;
    logic [LANES*DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0]       m_hi, m_lo, m_flags;
    logic                    m_we, m_flags_we;
    logic [2*DATA_W-1:0]     m_tmp;
    int unsigned             m_cnt;
    int unsigned             m_bub;

    task automatic model_clear_mem();
        m_valid = 0; m_wd = '0; m_wreg = '0; m_wdata = '0; m_hi = '0; m_lo = '0;
        m_we = 0; m_flags = '0; m_flags_we = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_clear_mem();
            m_tmp = '0; m_cnt = 0; m_bub = 0;
        end else if (flush) begin
            model_clear_mem();
            m_tmp = '0; m_cnt = 0;
        end else if (stall[STAGE] && stall[STAGE+1]) begin
            // hold: nothing changes
        end else if (stall[STAGE]) begin
            model_clear_mem();
            m_tmp = ex_hilo_tmp; m_cnt = ex_cnt;
            if (m_bub < (1 << PERF_W) - 1) m_bub = m_bub + 1;
        end else begin
            m_valid = ex_valid; m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
            m_hi = ex_hi; m_lo = ex_lo; m_we = ex_we; m_flags = ex_flags;
            m_flags_we = ex_flags_we; m_tmp = '0; m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(mem_valid), 64'(m_valid));
            chk("wd", 64'(mem_wd), 64'(m_wd));
            chk("wreg", 64'(mem_wreg), 64'(m_wreg));
            chk("wdata", mem_wdata, m_wdata);
            chk("hi", 64'(mem_hi), 64'(m_hi));
            chk("lo", 64'(mem_lo), 64'(m_lo));
            chk("we", 64'(mem_we), 64'(m_we));
            chk("flags", 64'(mem_flags), 64'(m_flags));
            chk("flags_we", 64'(mem_flags_we), 64'(m_flags_we));
            chk("hilo_tmp", hilo_tmp_o, m_tmp);
            chk("cnt", 64'(cnt_o), 64'(m_cnt));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input int unsigned seed);
        ex_valid    = seed[0];
        ex_wd       = 10'(seed * 7);
        ex_wreg     = 2'(seed);
        ex_wdata    = {32'(seed * 32'h01010101), 32'(~seed)};
        ex_hi       = 32'(seed + 32'h100);
        ex_lo       = 32'(seed ^ 32'h5A5A5A5A);
        ex_we       = seed[1];
        ex_flags    = 32'(seed << 3);
        ex_flags_we = seed[2];
        ex_hilo_tmp = {32'(seed), 32'(seed * 3)};
        ex_cnt      = 2'(seed);
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0;
        set_ex(0);
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset valid", 64'(mem_valid), 64'd0);
        chk("reset bubble", 64'(bubble_cnt), 64'd0);
        rst = 1'b0;

        // 1: two-lane load
        ex_wd = {5'd9, 5'd3}; ex_wreg = 2'b11; ex_wdata = {32'hAAAA0000, 32'h12345678};
        ex_valid = 1'b1; stall = '0;
        tick();
        chk("t1 wd", 64'(mem_wd), 64'h123);
        chk("t1 wdata", mem_wdata, 64'hAAAA0000_12345678);
        chk("t1 wreg", 64'(mem_wreg), 64'd3);
        chk("t1 valid", 64'(mem_valid), 64'd1);
        chk("t1 cnt", 64'(cnt_o), 64'd0);

        // 2: bubble captures multi-cycle state, then load clears it
        stall = 6'b001111; ex_hilo_tmp = 64'h0000_0001_FFFF_FFFE; ex_cnt = 2'd1;
        tick();
        chk("t2 wreg", 64'(mem_wreg), 64'd0);
        chk("t2 valid", 64'(mem_valid), 64'd0);
        chk("t2 tmp", hilo_tmp_o, 64'h0000_0001_FFFF_FFFE);
        chk("t2 cnt", 64'(cnt_o), 64'd1);
        chk("t2 bubble", 64'(bubble_cnt), 64'd1);
        stall = '0;
        tick();
        chk("t2 tmp cleared", hilo_tmp_o, 64'd0);
        chk("t2 cnt cleared", 64'(cnt_o), 64'd0);

        // 3: hold keeps everything while EX inputs churn
        ex_wdata = {32'h0, 32'hDEADBEEF};
        tick();
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(i + 11);
            tick();
        end
        chk("t3 wdata", 64'(mem_wdata[31:0]), 64'hDEADBEEF);
        chk("t3 bubble", 64'(bubble_cnt), 64'd1);

        // 4: flush wins over a bubble-shaped stall
        stall = 6'b001111; ex_hilo_tmp = 64'h1234; ex_cnt = 2'd3;
        tick();
        flush = 1'b1;
        tick();
        chk("t4 wreg", 64'(mem_wreg), 64'd0);
        chk("t4 tmp", hilo_tmp_o, 64'd0);
        chk("t4 bubble", 64'(bubble_cnt), 64'd2);
        flush = 1'b0;

        // Illegal s_here=0/s_next=1 acts as a load; loads with ex_valid=0 copy verbatim
        for (int i = 0; i < 6; i++) begin
            set_ex(32'h37 + i * 5);
            stall = (i % 2 == 0) ? 6'b010111 : 6'b000000;
            tick();
        end

        // 5: bubble counter saturates
        stall = 6'b001111;
        for (int i = 0; i < 20; i++) begin
            set_ex(i + 3);
            tick();
        end
        chk("t5 sat", 64'(bubble_cnt), 64'hF);
        tick();
        chk("t5 sat hold", 64'(bubble_cnt), 64'hF);

        // 6: synchronous reset mid multi-cycle op
        ex_cnt = 2'd2; ex_hilo_tmp = 64'hCAFE;
        tick();
        chk("t6 cnt", 64'(cnt_o), 64'd2);
        rst = 1'b1;
        #2;
        chk("t6 pre-edge cnt", 64'(cnt_o), 64'd2);
        tick();
        chk("t6 cnt rst", 64'(cnt_o), 64'd0);
        chk("t6 tmp rst", hilo_tmp_o, 64'd0);
        chk("t6 bubble rst", 64'(bubble_cnt), 64'd0);
        rst = 1'b0; stall = '0;
        set_ex(5);
        tick();
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX→MEM pipeline register. It replaces the fixed single-lane EX/MEM latch.
- Supports LANES register write-back lanes for dual-issue configurations.
- Adds flush, a valid bit and flags write-enable.
- Preserves multi-cycle EX state (madd/msub partial HI/LO and cycle counter) across stalls and feeds it back to EX.
- Keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
DATA_W, 32, datapath width (GPR, HI, LO, flags)
ADDR_W, 5, register address width
LANES, 1, number of register write-back lanes (1..4)
STALL_W, 6, width of global stall vector
STAGE, 3, index of this register in stall vector; STAGE+1 < STALL_W required
CNT_W, 2, width of multi-cycle op counter
PERF_W, 16, width of bubble counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall  in  STALL_W  global stall vector, 1 = Stop
flush  in  1  discard stage contents (exception/redirect)
ex_valid  in  1  EX holds a real instruction
ex_wd  in  LANES*ADDR_W  dest reg per lane, lane i at [i*ADDR_W +: ADDR_W]
ex_wreg  in  LANES  write enable per lane
ex_wdata  in  LANES*DATA_W  write data per lane
ex_hi  in  DATA_W  HI result
ex_lo  in  DATA_W  LO result
ex_we  in  1  HI/LO write enable
ex_flags  in  DATA_W  flags result
ex_flags_we  in  1  flags write enable
ex_hilo_tmp  in  2*DATA_W  partial multi-cycle result from EX
ex_cnt  in  CNT_W  multi-cycle step counter from EX
mem_valid  out  1  MEM holds a real instruction
mem_wd  out  LANES*ADDR_W  registered ex_wd
mem_wreg  out  LANES  registered ex_wreg
mem_wdata  out  LANES*DATA_W  registered ex_wdata
mem_hi  out  DATA_W  registered ex_hi
mem_lo  out  DATA_W  registered ex_lo
mem_we  out  1  registered ex_we
mem_flags  out  DATA_W  registered ex_flags
mem_flags_we  out  1  registered ex_flags_we
hilo_tmp_o  out  2*DATA_W  saved partial result, fed back to EX
cnt_o  out  CNT_W  saved step counter, fed back to EX
bubble_cnt  out  PERF_W  number of bubbles inserted since reset

Behaviour:
- All registers update on posedge clk only; no combinational path from input to output.
- Let s_here = stall[STAGE] and s_next = stall[STAGE+1].
- Per-cycle action, highest priority first:
  1. RESET (rst=1): every output = 0. mem_wd lanes = 0 (NOP reg addr). bubble_cnt = 0.
  2. FLUSH (flush=1): all mem_* = 0, mem_valid = 0, hilo_tmp_o = 0, cnt_o = 0. Not counted as a bubble. Flush overrides any stall.
  3. BUBBLE (s_here=1, s_next=0): all mem_* = 0, mem_valid = 0.
     - hilo_tmp_o <= ex_hilo_tmp; cnt_o <= ex_cnt, so EX resumes the multi-cycle op.
     - bubble_cnt += 1, saturating at all-ones.
  4. HOLD (s_here=1, s_next=1): every register keeps its value, including tmp/cnt and bubble_cnt.
  5. LOAD (s_here=0): mem_* <= ex_*.
     - mem_valid <= ex_valid.
     - hilo_tmp_o = 0 and cnt_o = 0: the op has completed and its state is cleared.
- s_here=0 with s_next=1 is illegal. The block treats it as LOAD; the stall controller never generates it.
- On LOAD with ex_valid=0, fields are still copied verbatim. Downstream qualifies writes with mem_valid only through the wreg/we/flags_we bits, which EX drives to 0 for invalid slots.
- Lanes are independent bit slices. LANES=1 is bit-identical to the single-lane latch plus the added ports.
- Latency: exactly 1 cycle on LOAD. The fed-back tmp/cnt are visible to EX the cycle after BUBBLE.
- Reset mid multi-cycle op clears tmp/cnt; EX restarts from cnt=0.

Test Plan:
1. Reset then LOAD, LANES=2: ex_wd={5'd9,5'd3}, ex_wreg=2'b11, ex_wdata={32'hAAAA0000,32'h12345678}, ex_valid=1, stall=0 → next cycle mem_wd/mem_wdata/mem_wreg match, mem_valid=1, cnt_o=0.
2. BUBBLE with tmp capture: stall=6'b001111, ex_hilo_tmp=64'h0000_0001_FFFF_FFFE, ex_cnt=1 → mem_wreg=0, mem_valid=0, hilo_tmp_o=64'h0000_0001_FFFF_FFFE, cnt_o=1, bubble_cnt=1. Then stall=0 → LOAD, tmp/cnt back to 0.
3. HOLD: load mem_wdata=32'hDEADBEEF, then stall=6'b011111 for 3 cycles with changing ex_* → mem_wdata stays 32'hDEADBEEF, bubble_cnt unchanged.
4. Flush priority: stall=6'b001111 and flush=1 in the same cycle → all mem_* = 0, hilo_tmp_o = 0, bubble_cnt not incremented.
5. Saturation: PERF_W=4, 20 consecutive BUBBLE cycles → bubble_cnt=4'hF and stays.
6. Sync reset mid-op: cnt_o=2 after BUBBLE, assert rst one cycle → cnt_o=0, hilo_tmp_o=0, bubble_cnt=0 on the following edge; no change before the edge.
